score_credit_queue: RTL and testbench

Upstream feeder for the score board. Collects per-player score credits from the blast and kill logic, including several credits arriving in one cycle or for both players at once, into saturating pending counters. Drains them as single-cycle `p1gain`/`p2gain` pulses, at most one per player per `GAP` cycles, so the BCD score board never misses an increment.

---
 rtl/score_credit_queue_if.sv | 27 ++
 rtl/score_credit_queue.sv | 97 +++++++++
 tb/tb_score_credit_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_credit_queue_if.sv
// Credit input / gain output bundle of the score credit queue.
interface score_credit_queue_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       p1credit;
  logic [1:0]       p2credit;
  logic             hold;
  logic             flush;
  logic             p1gain;
  logic             p2gain;
  logic [CNT_W-1:0] p1pending;
  logic [CNT_W-1:0] p2pending;
  logic             p1ovf;
  logic             p2ovf;

  modport master (
    output p1credit, p2credit, hold, flush,
    input  p1gain, p2gain, p1pending, p2pending,
    input  p1ovf, p2ovf
  );

  modport slave (
    input  p1credit, p2credit, hold, flush,
    output p1gain, p2gain, p1pending, p2pending,
    output p1ovf, p2ovf
  );
endinterface

// File: rtl/score_credit_queue.sv
// Two-lane saturating credit queue draining GAP-spaced gain pulses.
// Optional sticky overflow flags: define SCORE_QUEUE_OVF_EN.
module score_credit_queue #(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input logic Clk,
  input logic Reset_n,
  score_credit_queue_if.slave bus
);
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);
  localparam logic [3:0] TLOAD = 4'(GAP - 1);

  logic [CNT_W-1:0] pend_q [2];
  logic [CNT_W-1:0] pend_d [2];
  logic [3:0]       tmr_q  [2];
  logic [3:0]       tmr_d  [2];
  logic [1:0]       cr     [2];
  logic [SW-1:0]    sum    [2];
  logic [1:0]       gain_q, gain_d;
  logic [1:0]       iss;
  logic [1:0]       sat;

  assign cr[0] = bus.p1credit;
  assign cr[1] = bus.p2credit;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      iss[i] = !bus.flush && !bus.hold &&
               (tmr_q[i] == 4'd0) &&
               (pend_q[i] != '0);
      sum[i] = {2'b00, pend_q[i]}
             + {{CNT_W{1'b0}}, cr[i]}
             - {{(CNT_W+1){1'b0}}, iss[i]};
      sat[i] = sum[i] > MAX;
      gain_d[i] = iss[i];
      pend_d[i] = sat[i] ? MAX[CNT_W-1:0]
                         : sum[i][CNT_W-1:0];
      if (iss[i])
        tmr_d[i] = TLOAD;
      else if (tmr_q[i] != 4'd0)
        tmr_d[i] = tmr_q[i] - 4'd1;
      else
        tmr_d[i] = tmr_q[i];
      // flush discards same-cycle credits too
      if (bus.flush) begin
        pend_d[i] = '0;
        tmr_d[i]  = 4'd0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gain_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= '0;
        tmr_q[i]  <= 4'd0;
      end
    end else begin
      gain_q <= gain_d;
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= pend_d[i];
        tmr_q[i]  <= tmr_d[i];
      end
    end
  end

  assign bus.p1gain    = gain_q[0];
  assign bus.p2gain    = gain_q[1];
  assign bus.p1pending = pend_q[0];
  assign bus.p2pending = pend_q[1];

`ifdef SCORE_QUEUE_OVF_EN
  logic [1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | sat;
    if (bus.flush)
      ovf_d = 2'b00;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      ovf_q <= 2'b00;
    else
      ovf_q <= ovf_d;
  end

  assign bus.p1ovf = ovf_q[0];
  assign bus.p2ovf = ovf_q[1];
`else
  assign bus.p1ovf = 1'b0;
  assign bus.p2ovf = 1'b0;
`endif
endmodule

// File: tb/tb_score_credit_queue.sv
// Directed bench for score_credit_queue (CNT_W=4, GAP=2).
module tb_score_credit_queue;
`ifdef SCORE_QUEUE_OVF_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  score_credit_queue_if #(.CNT_W(4)) bus();

  score_credit_queue #(.CNT_W(4), .GAP(2)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] p1c;
    logic [1:0] p2c;
    logic       hold;
    int         g1;
    int         g2;
    int         pp1;
    int         pp2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int p1c, input int p2c,
                     input int h, input int g1,
                     input int g2, input int pp1,
                     input int pp2);
    vec_t v;
    v.p1c = 2'(p1c);
    v.p2c = 2'(p2c);
    v.hold = 1'(h);
    v.g1 = g1;
    v.g2 = g2;
    v.pp1 = pp1;
    v.pp2 = pp2;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int p1c, input int p2c,
                       input int h, input int f);
    bus.p1credit = 2'(p1c);
    bus.p2credit = 2'(p2c);
    bus.hold = 1'(h);
    bus.flush = 1'(f);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_g1"}, int'(bus.p1gain), 0);
    chk({nm, "_g2"}, int'(bus.p2gain), 0);
    chk({nm, "_pp1"}, int'(bus.p1pending), 0);
    chk({nm, "_pp2"}, int'(bus.p2pending), 0);
    chk({nm, "_o1"}, int'(bus.p1ovf), 0);
    chk({nm, "_o2"}, int'(bus.p2ovf), 0);
  endtask

  initial begin
    int cnt;
    drive(0, 0, 0, 0);
    #2;
    chk_all_zero("reset");
    step();
    step();
    Reset_n = 1'b1;

    // single credit, lane 1
    add(1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // burst of 3 on lane 2
    add(0, 3, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // both lanes together
    add(2, 2, 0, 0, 0, 2, 2);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // hold then release
    add(1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      string s;
      drive(vq[i].p1c, vq[i].p2c, vq[i].hold, 0);
      step();
      s = $sformatf("v%0d", i);
      chk({s, "_g1"}, int'(bus.p1gain), vq[i].g1);
      chk({s, "_g2"}, int'(bus.p2gain), vq[i].g2);
      chk({s, "_pp1"}, int'(bus.p1pending), vq[i].pp1);
      chk({s, "_pp2"}, int'(bus.p2pending), vq[i].pp2);
    end

    // saturation: exactly full is not overflow
    for (int k = 0; k < 5; k++) begin
      drive(3, 0, 1, 0);
      step();
    end
    chk("sat_full_pp1", int'(bus.p1pending), 15);
    chk("sat_full_ovf", int'(bus.p1ovf), 0);
    drive(3, 0, 1, 0);
    step();
    chk("sat_pp1", int'(bus.p1pending), 15);
    chk("sat_ovf", int'(bus.p1ovf), OVF_EN);
    chk("sat_ovf2", int'(bus.p2ovf), 0);
    drive(0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.p1gain) cnt++;
    end
    chk("sat_pulses", cnt, 15);
    chk("sat_drained", int'(bus.p1pending), 0);
    chk("sat_sticky", int'(bus.p1ovf), OVF_EN);
    drive(0, 0, 0, 1);
    step();
    chk("flush_ovf", int'(bus.p1ovf), 0);

    // credit and drain at full count
    for (int k = 0; k < 5; k++) begin
      drive(3, 0, 1, 0);
      step();
    end
    drive(1, 0, 0, 0);
    step();
    chk("net_g1", int'(bus.p1gain), 1);
    chk("net_pp1", int'(bus.p1pending), 15);
    chk("net_ovf", int'(bus.p1ovf), 0);
    drive(0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.p1gain) cnt++;
    end
    chk("net_pulses", cnt, 15);

    // flush priority over same-cycle credit
    drive(3, 0, 1, 0);
    step();
    drive(2, 0, 1, 0);
    step();
    chk("fl_pp1_pre", int'(bus.p1pending), 5);
    drive(3, 0, 0, 1);
    step();
    chk("fl_pp1", int'(bus.p1pending), 0);
    chk("fl_ovf", int'(bus.p1ovf), 0);
    chk("fl_g1", int'(bus.p1gain), 0);
    drive(0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.p1gain) cnt++;
    end
    chk("fl_nopulse", cnt, 0);

    // async reset mid-drain
    drive(0, 2, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("rst_g2_pre", int'(bus.p2gain), 1);
    chk("rst_pp2_pre", int'(bus.p2pending), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    Reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.p2gain || bus.p1gain) cnt++;
    end
    chk("rst_nopulse", cnt, 0);
    chk("rst_pp2", int'(bus.p2pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end
endmodule
